ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes the byte stream popped from the PS/2 receive FIFO and turns Set-2 scan codes into key events.
//  Each event carries the make/break flag, the extended (E0) flag and an ASCII translation.
//  It sits directly downstream of the PS/2 receiver and feeds display/counter logic.
//  Tracks the currently held key, suppresses typematic repeats and counts key presses.
// PARAMETERS
//  CNT_W          8   width of press counter
//  SUPPRESS_RPT   1   1: repeated make of the held key emits no event; 0: every make emits
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  clrn         in   1      asynchronous active-low reset
//  code_valid   in   1      one-cycle qualifier: code holds a new scan byte
//  code         in   8      scan byte from receiver FIFO
//  key_valid    out  1      one-cycle pulse: key event fields valid
//  key_code     out  8      scan code of event (prefixes stripped)
//  key_ext      out  1      event was E0-prefixed
//  key_release  out  1      1 = break (F0), 0 = make
//  key_ascii    out  8      ASCII of key_code; 8'h00 if ext or unmapped
//  held_valid   out  1      a key is currently held
//  held_code    out  8      code of held key (held_ext gives E0 flag)
//  held_ext     out  1
//  press_cnt    out  CNT_W  emitted make events, wraps mod 2^CNT_W
//  err          out  1      one-cycle pulse on protocol error
// BEHAVIOUR
//  - Reset (clrn=0, async): state=S_IDLE, all outputs 0, held cleared, press_cnt=0.
//  - Bytes consumed only when code_valid=1. Other cycles: state unchanged, key_valid=err=0.
//  - All outputs are registered. key_valid/err assert exactly 1 cycle after the completing code_valid. Event fields hold until the next event.
//  - One byte per cycle accepted back-to-back; no backpressure.
//  - FSM states: S_IDLE, S_E0, S_F0, S_E0F0.
//    S_IDLE: E0->S_E0; F0->S_F0; AA/FA/EE/FE ignored; else make(ext=0).
//    S_E0:   F0->S_E0F0; E0->err, stay S_E0; else make(ext=1)->S_IDLE.
//    S_F0:   E0 or F0->err->S_IDLE; else break(ext=0)->S_IDLE.
//    S_E0F0: E0 or F0->err->S_IDLE; else break(ext=1)->S_IDLE.
//    In any state, 00 or FF (keyboard error) -> err pulse, S_IDLE, no event.
//  - Make handling:
//    - If SUPPRESS_RPT and held_valid and {held_ext,held_code} equals the new key: no key_valid, cnt unchanged.
//    - Otherwise emit the event, press_cnt+=1, and held becomes the new key (last make wins).
//  - Break: always emit the event. Clear held_valid only if the break matches {held_ext,held_code}.
//  - ASCII (ext=0 only):
//    - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 'a'..'z'.
//    - Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'.
//    - 29->20, 5A->0D, 66->08. All other codes -> 00.
//    - key_ascii is also set on break events.
//  - Reset mid-sequence discards any pending prefix. press_cnt wraps FF->00 with no flag.
// TESTING
//  1C -> key_valid 1 cycle later, code=1C, rel=0, ext=0, ascii=61, held=1C, cnt=1.
//  F0,1C -> break code=1C, rel=1, ascii=61, held_valid=0, cnt unchanged.
//  E0,75 then E0,F0,75 -> make ext=1 ascii=00; break ext=1; held cleared.
//  1C,1C,1C (SUPPRESS_RPT=1) -> 1 event, cnt=1. With SUPPRESS_RPT=0 -> 3 events, cnt=3.
//  F0,F0 -> err pulse, no event. Then 1C -> make (state back to IDLE). 00 -> err.
//  F0, clrn pulse, 1C -> make (not break); 256 makes of alternating keys -> cnt wraps to 0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the Set-2 scan byte stream from the PS/2 receive FIFO into key events.
//   It strips E0/F0 prefixes, tracks the currently held key, optionally suppresses
//   typematic repeats of the held key, counts emitted makes and flags protocol errors.
// Ports
//   clk          : system clock, rising edge
//   clrn         : asynchronous active-low reset
//   code_valid   : one-cycle qualifier for code
//   code         : scan byte
//   key_valid    : one-cycle pulse, event fields valid (fields hold until next event)
//   key_code     : scan code of the event with prefixes stripped
//   key_ext      : event was E0-prefixed
//   key_release  : 1 = break, 0 = make
//   key_ascii    : ASCII translation, 8'h00 for extended or unmapped keys
//   held_valid   : a key is currently held
//   held_code    : code of the held key
//   held_ext     : E0 flag of the held key
//   press_cnt    : emitted make events, wraps
//   err          : one-cycle pulse on protocol error
module ps2_scancode_decoder #(
    parameter int unsigned CNT_W        = 8,
    parameter bit          SUPPRESS_RPT = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             code_valid,
    input  logic [7:0]       code,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic [7:0]       key_ascii,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err
);

    localparam logic [7:0] C_E0 = 8'hE0;
    localparam logic [7:0] C_F0 = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_key_valid;
    logic [7:0]         r_key_code;
    logic               r_key_ext;
    logic               r_key_release;
    logic [7:0]         r_key_ascii;
    logic               r_held_valid;
    logic [7:0]         r_held_code;
    logic               r_held_ext;
    logic [CNT_W-1:0]   r_press_cnt;
    logic               r_err;

    logic               w_ext;
    logic               w_match;
    logic               w_suppress;
    logic               w_kbd_err;
    logic               w_ignored;
    logic [7:0]         w_ascii;

    // Set-2 to ASCII lookup for non-extended codes
    function automatic logic [7:0] f_ascii(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Extended flag of the key completed by the current byte follows the pending prefix
    assign w_ext      = (r_state == S_E0) || (r_state == S_E0F0);
    assign w_match    = r_held_valid && (r_held_ext == w_ext) && (r_held_code == code);
    assign w_suppress = SUPPRESS_RPT && w_match;
    assign w_kbd_err  = (code == 8'h00) || (code == 8'hFF);
    // BAT-complete, ACK, echo and resend bytes carry no key information
    assign w_ignored  = (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) || (code == 8'hFE);
    assign w_ascii    = w_ext ? 8'h00 : f_ascii(code);

    // Decoder FSM with registered event, held-key and counter outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state       <= S_IDLE;
            r_key_valid   <= 1'b0;
            r_key_code    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_release <= 1'b0;
            r_key_ascii   <= 8'h00;
            r_held_valid  <= 1'b0;
            r_held_code   <= 8'h00;
            r_held_ext    <= 1'b0;
            r_press_cnt   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            if (code_valid) begin
                if (w_kbd_err) begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (code == C_E0) begin
                                r_state <= S_E0;
                            end else if (code == C_F0) begin
                                r_state <= S_F0;
                            end else if (!w_ignored && !w_suppress) begin
                                r_key_valid   <= 1'b1;
                                r_key_code    <= code;
                                r_key_ext     <= 1'b0;
                                r_key_release <= 1'b0;
                                r_key_ascii   <= w_ascii;
                                r_press_cnt   <= r_press_cnt + CNT_W'(1);
                                r_held_valid  <= 1'b1;
                                r_held_code   <= code;
                                r_held_ext    <= 1'b0;
                            end
                        end
                        S_E0: begin
                            if (code == C_F0) begin
                                r_state <= S_E0F0;
                            end else if (code == C_E0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                if (!w_suppress) begin
                                    r_key_valid   <= 1'b1;
                                    r_key_code    <= code;
                                    r_key_ext     <= 1'b1;
                                    r_key_release <= 1'b0;
                                    r_key_ascii   <= w_ascii;
                                    r_press_cnt   <= r_press_cnt + CNT_W'(1);
                                    r_held_valid  <= 1'b1;
                                    r_held_code   <= code;
                                    r_held_ext    <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            // S_F0 and S_E0F0: byte completes a break
                            r_state <= S_IDLE;
                            if ((code == C_E0) || (code == C_F0)) begin
                                r_err <= 1'b1;
                            end else begin
                                r_key_valid   <= 1'b1;
                                r_key_code    <= code;
                                r_key_ext     <= w_ext;
                                r_key_release <= 1'b1;
                                r_key_ascii   <= w_ascii;
                                if (w_match) begin
                                    r_held_valid <= 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_ext     = r_key_ext;
    assign key_release = r_key_release;
    assign key_ascii   = r_key_ascii;
    assign held_valid  = r_held_valid;
    assign held_code   = r_held_code;
    assign held_ext    = r_held_ext;
    assign press_cnt   = r_press_cnt;
    assign err         = r_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//   Drives two decoders (repeat suppression on and off) with the same byte stream:
//   directed sequences first, then random traffic with occasional resets, and
//   compares every output each cycle against a prefix-queue reference model.
module tb_ps2_scancode_decoder;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             clrn;
    logic             code_valid;
    logic [7:0]       code;

    logic             kv [2];
    logic [7:0]       kc [2];
    logic             ke [2];
    logic             kr [2];
    logic [7:0]       ka [2];
    logic             hv [2];
    logic [7:0]       hc [2];
    logic             he [2];
    logic [CNT_W-1:0] pc [2];
    logic             er [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.CNT_W(CNT_W), .SUPPRESS_RPT(1'b1)) u_dut_sup (
        .clk(clk), .clrn(clrn), .code_valid(code_valid), .code(code),
        .key_valid(kv[0]), .key_code(kc[0]), .key_ext(ke[0]), .key_release(kr[0]),
        .key_ascii(ka[0]), .held_valid(hv[0]), .held_code(hc[0]), .held_ext(he[0]),
        .press_cnt(pc[0]), .err(er[0])
    );

    ps2_scancode_decoder #(.CNT_W(CNT_W), .SUPPRESS_RPT(1'b0)) u_dut_all (
        .clk(clk), .clrn(clrn), .code_valid(code_valid), .code(code),
        .key_valid(kv[1]), .key_code(kc[1]), .key_ext(ke[1]), .key_release(kr[1]),
        .key_ascii(ka[1]), .held_valid(hv[1]), .held_code(hc[1]), .held_ext(he[1]),
        .press_cnt(pc[1]), .err(er[1])
    );

    // Reference model: pending prefixes kept as a byte list, per-instance key state
    logic [7:0]       pend [$];
    logic             m_kv [2];
    logic [7:0]       m_kc [2];
    logic             m_ke [2];
    logic             m_kr [2];
    logic [7:0]       m_ka [2];
    logic             m_hv [2];
    logic [7:0]       m_hc [2];
    logic             m_he [2];
    logic [CNT_W-1:0] m_pc [2];
    logic             m_er [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        logic [7:0] letters [26];
        logic [7:0] digits [10];
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int k = 0; k < 26; k++) if (letters[k] == c) return 8'h61 + 8'(k);
        for (int k = 0; k < 10; k++) if (digits[k] == c) return 8'h30 + 8'(k);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            m_kv[i] = 0; m_kc[i] = 0; m_ke[i] = 0; m_kr[i] = 0; m_ka[i] = 0;
            m_hv[i] = 0; m_hc[i] = 0; m_he[i] = 0; m_pc[i] = 0; m_er[i] = 0;
        end
    endtask

    task automatic model_idle();
        for (int i = 0; i < 2; i++) begin
            m_kv[i] = 0;
            m_er[i] = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_key = 0;
        bit bad = 0;
        bit ext = 0;
        bit rel = 0;
        bit match;
        model_idle();
        if (b == 8'h00 || b == 8'hFF) begin
            bad = 1;
            pend.delete();
        end else if (b == 8'hE0) begin
            if (pend.size() == 0) pend.push_back(b);
            else if (pend.size() == 1 && pend[0] == 8'hE0) bad = 1;
            else begin bad = 1; pend.delete(); end
        end else if (b == 8'hF0) begin
            if (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0)) pend.push_back(b);
            else begin bad = 1; pend.delete(); end
        end else if (pend.size() == 0 && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
            is_key = 0;
        end else begin
            foreach (pend[k]) begin
                if (pend[k] == 8'hE0) ext = 1;
                if (pend[k] == 8'hF0) rel = 1;
            end
            pend.delete();
            is_key = 1;
        end
        for (int i = 0; i < 2; i++) begin
            m_er[i] = bad;
            if (is_key) begin
                match = m_hv[i] && (m_he[i] == ext) && (m_hc[i] == b);
                if (!(i == 0 && !rel && match)) begin
                    m_kv[i] = 1; m_kc[i] = b; m_ke[i] = ext; m_kr[i] = rel;
                    m_ka[i] = ext ? 8'h00 : ascii_of(b);
                    if (!rel) begin
                        m_pc[i] = m_pc[i] + 1'b1;
                        m_hv[i] = 1; m_hc[i] = b; m_he[i] = ext;
                    end else if (match) begin
                        m_hv[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("key_valid[%0d]", i), 32'(kv[i]), 32'(m_kv[i]));
            check_val($sformatf("err[%0d]", i), 32'(er[i]), 32'(m_er[i]));
            check_val($sformatf("key_code[%0d]", i), 32'(kc[i]), 32'(m_kc[i]));
            check_val($sformatf("key_ext[%0d]", i), 32'(ke[i]), 32'(m_ke[i]));
            check_val($sformatf("key_release[%0d]", i), 32'(kr[i]), 32'(m_kr[i]));
            check_val($sformatf("key_ascii[%0d]", i), 32'(ka[i]), 32'(m_ka[i]));
            check_val($sformatf("held_valid[%0d]", i), 32'(hv[i]), 32'(m_hv[i]));
            check_val($sformatf("press_cnt[%0d]", i), 32'(pc[i]), 32'(m_pc[i]));
            if (m_hv[i]) begin
                check_val($sformatf("held_code[%0d]", i), 32'(hc[i]), 32'(m_hc[i]));
                check_val($sformatf("held_ext[%0d]", i), 32'(he[i]), 32'(m_he[i]));
            end
        end
    endtask

    task automatic send(input bit v, input logic [7:0] b);
        @(negedge clk);
        code_valid = v;
        code       = b;
        @(posedge clk);
        #1;
        if (v) model_byte(b);
        else   model_idle();
        check_all();
    endtask

    // Async reset pulse inside a clock low phase; outputs must clear immediately
    task automatic pulse_reset();
        @(negedge clk);
        code_valid = 1'b0;
        #1 clrn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rst held_code[%0d]", i), 32'(hc[i]), 32'h0);
            check_val($sformatf("rst held_ext[%0d]", i), 32'(he[i]), 32'h0);
        end
        check_all();
        #2 clrn = 1'b1;
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[k]) send(1'b1, s[k]);
    endtask

    initial begin
        logic [7:0] pool [8];
        int r;
        pool = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h45, 8'h66, 8'h6B};
        clrn       = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        model_reset();
        #12;
        check_all();
        clrn = 1'b1;

        // Make, then break of the same key
        send(1'b1, 8'h1C);
        check_val("dir make ascii", 32'(ka[0]), 32'h61);
        check_val("dir make cnt", 32'(pc[0]), 32'd1);
        send_seq('{8'hF0, 8'h1C});
        check_val("dir break rel", 32'(kr[0]), 32'd1);
        check_val("dir break held", 32'(hv[0]), 32'd0);
        // Extended make and break
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        check_val("dir ext break", 32'(ke[0]), 32'd1);
        // Typematic repeats
        pulse_reset();
        send_seq('{8'h1C, 8'h1C, 8'h1C});
        check_val("dir rpt cnt sup", 32'(pc[0]), 32'd1);
        check_val("dir rpt cnt all", 32'(pc[1]), 32'd3);
        // Protocol errors and recovery
        send_seq('{8'hF0, 8'hF0});
        check_val("dir ff err", 32'(er[0]), 32'd1);
        send_seq('{8'h32, 8'h00, 8'hE0, 8'hE0, 8'h29, 8'hAA, 8'hFA, 8'hE0, 8'hAA});
        send(1'b0, 8'h1C);
        // Reset discards a pending break prefix
        send(1'b1, 8'hF0);
        pulse_reset();
        send(1'b1, 8'h1C);
        check_val("dir post-rst make", 32'(kr[0]), 32'd0);
        // Counter wrap with alternating keys
        pulse_reset();
        for (int k = 0; k < 256; k++) send(1'b1, (k % 2) ? 8'h32 : 8'h1C);
        check_val("dir wrap cnt sup", 32'(pc[0]), 32'd0);
        check_val("dir wrap cnt all", 32'(pc[1]), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                pulse_reset();
            end else begin
                r = r % 100;
                if      (r < 10) send(1'b0, 8'($urandom));
                else if (r < 22) send(1'b1, 8'hE0);
                else if (r < 34) send(1'b1, 8'hF0);
                else if (r < 37) send(1'b1, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF);
                else if (r < 40) send(1'b1, 8'hAA ^ 8'($urandom_range(0, 1) * 8'h50));
                else if (r < 43) send(1'b1, 8'($urandom));
                else             send(1'b1, pool[$urandom_range(0, 7)]);
            end
        end

        @(negedge clk);
        code_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
